// File: rtl/alu_seq.sv
// Multi-accumulator 8-bit-class ALU with shared flags, 1-bit shifts/rotates and an
// iterative unsigned shift-add multiplier, driven by an exec/busy/done handshake.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int NUM_ACC = 4,
    parameter int SEL_W   = $clog2(NUM_ACC)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             exec,
    input  logic [3:0]       op,
    input  logic [SEL_W-1:0] acc_sel,
    input  logic             oper2_sel,
    input  logic [WIDTH-1:0] IBR,
    input  logic [WIDTH-1:0] MBR,
    input  logic [SEL_W-1:0] acc_rd_sel,
    output logic [WIDTH-1:0] acc_rd,
    output logic [WIDTH-1:0] HI,
    output logic [3:0]       Flags,
    output logic             busy,
    output logic             done
);
    localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADDC = 4'd1,  OP_SUB  = 4'd2,  OP_SUBC = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4,  OP_NAND = 4'd5,  OP_XOR  = 4'd6,  OP_XNOR = 4'd7;
    localparam logic [3:0] OP_LOAD = 4'd8,  OP_SHL  = 4'd9,  OP_SHR  = 4'd10, OP_ASR  = 4'd11;
    localparam logic [3:0] OP_ROL  = 4'd12, OP_ROR  = 4'd13, OP_MUL  = 4'd14;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0]   acc_q [NUM_ACC];
    logic [NUM_ACC-1:0] acc_wen;
    logic [WIDTH-1:0]   hi_q, hi_d, mcand_q, mcand_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q, done_d;
    logic [SEL_W-1:0]   dst_q, dst_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept, last_iter, acc_we, carry, ov;
    logic [SEL_W-1:0]   acc_wsel;
    logic [WIDTH-1:0]   acc_wdata, opa, opb, res;
    logic [WIDTH:0]     arith, mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign accept    = exec && (state_q == S_IDLE);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign opa       = acc_q[acc_sel];
    assign opb       = oper2_sel ? MBR : IBR;

    // One shift-add step: the multiplier sits in the low half and is consumed LSB-first.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (arst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && op == OP_MUL) state_d = S_MUL;
            S_MUL:   if (last_iter) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_MUL);
    end

    always_comb begin
        hi_d      = hi_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        dst_d     = dst_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        acc_we    = 1'b0;
        acc_wsel  = acc_sel;
        acc_wdata = '0;
        arith     = '0;
        res       = '0;
        carry     = flags_q[0];
        ov        = flags_q[1];
        if (state_q == S_MUL) begin
            prod_d = mul_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_iter) begin
                acc_we     = 1'b1;
                acc_wsel   = dst_q;
                acc_wdata  = mul_next[WIDTH-1:0];
                hi_d       = mul_next[2*WIDTH-1:WIDTH];
                flags_d[0] = |mul_next[2*WIDTH-1:WIDTH];
                flags_d[1] = |mul_next[2*WIDTH-1:WIDTH];
                flags_d[2] = (mul_next == '0);
                done_d     = 1'b1;
            end
        end else if (accept) begin
            done_d = (op != OP_MUL);
            acc_we = (op != OP_MUL) && (op != 4'd15);
            case (op)
                OP_ADD, OP_ADDC: begin
                    arith = {1'b0, opa} + {1'b0, opb}
                          + ((op == OP_ADDC) ? {{WIDTH{1'b0}}, flags_q[0]} : '0);
                    res   = arith[WIDTH-1:0];
                    carry = arith[WIDTH];
                    ov    = (opa[WIDTH-1] == opb[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
                end
                OP_SUB, OP_SUBC: begin
                    arith = {1'b0, opa} - {1'b0, opb}
                          - ((op == OP_SUBC) ? {{WIDTH{1'b0}}, flags_q[0]} : '0);
                    res   = arith[WIDTH-1:0];
                    carry = arith[WIDTH];
                    ov    = (opa[WIDTH-1] != opb[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
                end
                OP_NOR:  res = ~(opa | opb);
                OP_NAND: res = ~(opa & opb);
                OP_XOR:  res = opa ^ opb;
                OP_XNOR: res = ~(opa ^ opb);
                OP_LOAD: res = opb;
                OP_SHL:  begin res = {opa[WIDTH-2:0], 1'b0};         carry = opa[WIDTH-1]; end
                OP_SHR:  begin res = {1'b0, opa[WIDTH-1:1]};         carry = opa[0];       end
                OP_ASR:  begin res = {opa[WIDTH-1], opa[WIDTH-1:1]}; carry = opa[0];       end
                OP_ROL:  begin res = {opa[WIDTH-2:0], opa[WIDTH-1]}; carry = opa[WIDTH-1]; end
                OP_ROR:  begin res = {opa[0], opa[WIDTH-1:1]};       carry = opa[0];       end
                OP_MUL: begin
                    dst_d   = acc_sel;
                    mcand_d = opa;
                    prod_d  = {{WIDTH{1'b0}}, opb};
                    cnt_d   = '0;
                end
                default: ;
            endcase
            if (acc_we) begin
                acc_wdata = res;
                flags_d   = {res[WIDTH-1], (res == '0), ov, carry};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            hi_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            dst_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            hi_q    <= hi_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            dst_q   <= dst_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ACC; gi++) begin : g_wen
            assign acc_wen[gi] = acc_we && (acc_wsel == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ACC; i++) begin
            if (arst)           acc_q[i] <= '0;
            else if (acc_wen[i]) acc_q[i] <= acc_wdata;
        end
    end

    assign acc_rd = acc_q[acc_rd_sel];
    assign HI     = hi_q;
    assign Flags  = flags_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq against an arithmetic reference model of the accumulator bank.
module tb_alu_seq;
    localparam int W = 8;
    localparam int N = 4;
    localparam int MASK = 255;
    localparam int MSB  = 128;

    logic       clk = 1'b0;
    logic       arst, exec, oper2_sel;
    logic [3:0] op;
    logic [1:0] acc_sel, acc_rd_sel;
    logic [7:0] IBR, MBR, acc_rd, HI;
    logic [3:0] Flags;
    logic       busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int m_acc [N];
    int m_hi, m_flags;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .NUM_ACC(N)) dut (
        .clk(clk), .arst(arst), .exec(exec), .op(op), .acc_sel(acc_sel),
        .oper2_sel(oper2_sel), .IBR(IBR), .MBR(MBR), .acc_rd_sel(acc_rd_sel),
        .acc_rd(acc_rd), .HI(HI), .Flags(Flags), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_acc(input int sel, output int val);
        acc_rd_sel = sel[1:0];
        #1;
        val = int'(acc_rd);
    endtask

    task automatic check_all(input string tag);
        int v;
        for (int i = 0; i < N; i++) begin
            read_acc(i, v);
            check($sformatf("%s_acc%0d", tag, i), v, m_acc[i]);
        end
        check({tag, "_hi"}, HI, m_hi);
        check({tag, "_flags"}, Flags, m_flags);
    endtask

    // Reference: results from integer arithmetic on the accumulator values.
    task automatic model_op(input int opc, input int sel, input int b);
        int a, r, res, c, ov, z, n, p;
        bit wr;
        a   = m_acc[sel];
        c   = m_flags & 1;
        ov  = (m_flags >> 1) & 1;
        n   = (m_flags >> 3) & 1;
        z   = (m_flags >> 2) & 1;
        res = a;
        wr  = 1;
        case (opc)
            0, 1: begin
                r   = a + b + ((opc == 1) ? c : 0);
                res = r & MASK;
                c   = (r > MASK) ? 1 : 0;
                ov  = (((a & MSB) == (b & MSB)) && ((res & MSB) != (a & MSB))) ? 1 : 0;
            end
            2, 3: begin
                r   = a - b - ((opc == 3) ? c : 0);
                res = r & MASK;
                c   = (r < 0) ? 1 : 0;
                ov  = (((a & MSB) != (b & MSB)) && ((res & MSB) != (a & MSB))) ? 1 : 0;
            end
            4:  res = ~(a | b) & MASK;
            5:  res = ~(a & b) & MASK;
            6:  res = (a ^ b) & MASK;
            7:  res = ~(a ^ b) & MASK;
            8:  res = b;
            9:  begin res = (a << 1) & MASK;                 c = a >> (W - 1); end
            10: begin res = a >> 1;                           c = a & 1;        end
            11: begin res = (a >> 1) | (a & MSB);             c = a & 1;        end
            12: begin res = ((a << 1) & MASK) | (a >> (W-1)); c = a >> (W - 1); end
            13: begin res = (a >> 1) | ((a & 1) << (W - 1));  c = a & 1;        end
            14: begin
                p    = a * b;
                res  = p & MASK;
                m_hi = p >> W;
                c    = (m_hi != 0) ? 1 : 0;
                ov   = c;
                z    = (p == 0) ? 1 : 0;
                wr   = 0;
            end
            default: wr = 0;
        endcase
        if (wr) begin
            z = (res == 0) ? 1 : 0;
            n = (res & MSB) ? 1 : 0;
        end
        if (opc != 15) begin
            m_acc[sel] = res;
            m_flags    = c | (ov << 1) | (z << 2) | (n << 3);
        end
    endtask

    // Starts and ends at a negedge; exec is presented immediately.
    task automatic run_op(input int opc, input int sel, input int o2, input int ibr_v,
                          input int mbr_v, input bit inject);
        int b, old, cyc;
        b   = o2 ? mbr_v : ibr_v;
        old = m_acc[sel];
        exec = 1'b1; op = opc[3:0]; acc_sel = sel[1:0]; oper2_sel = o2[0];
        IBR = ibr_v[7:0]; MBR = mbr_v[7:0];
        @(posedge clk);
        @(negedge clk);
        exec = 1'b0;
        model_op(opc, sel, b);
        $display("op=%0d acc%0d A=0x%02h B=0x%02h -> acc=0x%02h hi=0x%02h flags=0x%0h",
                 opc, sel, old, b, m_acc[sel], m_hi, m_flags);
        if (opc != 14) begin
            check("busy_single", busy, 0);
            check("done_pulse", done, 1);
        end else begin
            cyc = 0;
            while (busy === 1'b1 && cyc < 40) begin
                if (cyc == 0) check("done_during_mul", done, 0);
                if (cyc == 1) begin
                    acc_rd_sel = sel[1:0];
                    #1;
                    check("rd_old_during_mul", acc_rd, old);
                end
                if (inject && cyc == 2) begin
                    exec = 1'b1; op = 4'd0; acc_sel = 2'd0; oper2_sel = 1'b0;
                    IBR = 8'($urandom_range(1, 255));
                end
                if (cyc == 4) exec = 1'b0;
                @(negedge clk);
                cyc++;
            end
            exec = 1'b0;
            check("mul_busy_cycles", cyc, W);
            check("mul_done", done, 1);
        end
        check_all("post");
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_acc[i] = 0;
        m_hi = 0;
        m_flags = 0;
    endtask

    initial begin
        int v;
        arst = 1'b1; exec = 1'b0; op = 4'd15; acc_sel = '0; oper2_sel = 1'b0;
        IBR = '0; MBR = '0; acc_rd_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_all("rst");

        // ADD overflow into sign bit
        run_op(8, 0, 0, 8'h7F, 0, 0);
        run_op(0, 0, 0, 8'h01, 0, 0);
        read_acc(0, v); check("plan_add_acc", v, 8'h80); check("plan_add_flags", Flags, 4'hA);
        // SUB from MBR then SUBC with borrow
        run_op(2, 1, 1, 0, 8'h01, 0);
        read_acc(1, v); check("plan_sub_acc", v, 8'hFF); check("plan_sub_flags", Flags, 4'h9);
        run_op(3, 1, 0, 8'h00, 0, 0);
        read_acc(1, v); check("plan_subc_acc", v, 8'hFE); check("plan_subc_c", Flags[0], 0);
        // rotate / shift chain
        run_op(8, 2, 0, 8'h01, 0, 0);
        run_op(13, 2, 0, 0, 0, 0);
        read_acc(2, v); check("plan_ror_acc", v, 8'h80); check("plan_ror_flags", Flags, 4'h9);
        run_op(11, 2, 0, 0, 0, 0);
        read_acc(2, v); check("plan_asr_acc", v, 8'hC0); check("plan_asr_c", Flags[0], 0);
        run_op(9, 2, 0, 0, 0, 0);
        read_acc(2, v); check("plan_shl_acc", v, 8'h80); check("plan_shl_c", Flags[0], 1);
        // MUL with an exec injected while busy
        run_op(8, 3, 0, 8'hFF, 0, 0);
        run_op(14, 3, 0, 8'hFF, 0, 1);
        read_acc(3, v); check("plan_mul_lo", v, 8'h01); check("plan_mul_hi", HI, 8'hFE);
        check("plan_mul_flags", Flags[2:0], 3'b011);
        read_acc(0, v); check("plan_busy_reject_acc0", v, 8'h80);
        run_op(8, 3, 0, 8'h0F, 0, 0);
        run_op(14, 3, 0, 8'h11, 0, 0);
        read_acc(3, v); check("plan_mul2_lo", v, 8'hFF); check("plan_mul2_hi", HI, 8'h00);
        check("plan_mul2_c", Flags[0], 0);

        // reset during MUL iteration 3
        exec = 1'b1; op = 4'd14; acc_sel = 2'd0; oper2_sel = 1'b0; IBR = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        exec = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        model_reset();
        check("midmul_busy", busy, 0);
        check("midmul_done", done, 0);
        check_all("midmul");
        run_op(8, 1, 1, 0, 8'h3C, 0);
        @(negedge clk);
        check("midmul_busy_after", busy, 0);

        // exec coincident with reset: reset wins
        arst = 1'b1; exec = 1'b1; op = 4'd8; acc_sel = 2'd2; IBR = 8'h77; oper2_sel = 1'b0;
        @(negedge clk);
        arst = 1'b0; exec = 1'b0;
        model_reset();
        check("rst_exec_done", done, 0);
        check_all("rst_exec");

        for (int k = 0; k < 150; k++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
